// File: rtl/lsu_queue.sv
// In-order load/store queue between the decoder and the dcache/CDB.
// Optional misaligned-access exception: define LSU_MISALIGN_EXC_EN.
module lsu_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ROB_W-1:0]  in_rob,
  input  logic [DATA_W-1:0] in_offset,
  input  logic [TAG_W-1:0]  in_base_tag,
  input  logic [DATA_W-1:0] in_base,
  input  logic [TAG_W-1:0]  in_sd_tag,
  input  logic [DATA_W-1:0] in_sd,
  input  logic [TAG_W-1:0]  cdb_in_tag,
  input  logic [DATA_W-1:0] cdb_in_data,
  output logic              cdb_out_valid,
  input  logic              grnt,
  output logic [TAG_W-1:0]  cdb_out_tag,
  output logic [DATA_W-1:0] cdb_out_data,
  output logic [ADDR_W-1:0] cdb_out_addr,
`ifdef LSU_MISALIGN_EXC_EN
  output logic              cdb_out_exc,
`endif
  input  logic              rob_stall,
  output logic              dcache_req,
  output logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_ack,
  input  logic              dcache_done,
  input  logic [DATA_W-1:0] dcache_data
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] NOLOCK = '1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_REQ  = 3'd1;
  localparam logic [2:0] LD_WAIT = 3'd2;
  localparam logic [2:0] BCAST   = 3'd3;
  localparam logic [2:0] DRAIN   = 3'd4;

  logic [DEPTH-1:0]  q_v;
  logic [3:0]        q_op   [DEPTH];
  logic [ROB_W-1:0]  q_rob  [DEPTH];
  logic [DATA_W-1:0] q_off  [DEPTH];
  logic [TAG_W-1:0]  q_btag [DEPTH];
  logic [DATA_W-1:0] q_base [DEPTH];
  logic [TAG_W-1:0]  q_stag [DEPTH];
  logic [DATA_W-1:0] q_sd   [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic [2:0]    state;

  logic [3:0]        cur_op;
  logic [ROB_W-1:0]  cur_rob;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] res_data;
  logic [ADDR_W-1:0] res_addr;
  logic              res_exc;

  logic              enq, pop, bcast, h_rdy, snoop;
  logic [ADDR_W-1:0] h_addr;
  logic [3:0]        h_op;

  function automatic logic [DATA_W-1:0] extract(
    input logic [3:0]        op,
    input logic [1:0]        lo,
    input logic [DATA_W-1:0] w
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    unique case (op[1:0])
      2'd0:    extract = {{(DATA_W-8){~op[2] & b[7]}}, b};
      2'd1:    extract = {{(DATA_W-16){~op[2] & h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  // Head-entry view and handshake qualifiers
  always_comb begin
    h_op   = q_op[head];
    h_addr = q_base[head][ADDR_W-1:0] + q_off[head][ADDR_W-1:0];
    h_rdy  = q_v[head] && (q_btag[head] == NOLOCK) &&
             (!h_op[3] || (q_stag[head] == NOLOCK));
    snoop  = (cdb_in_tag != NOLOCK);
    bcast  = (state == BCAST);
    in_ready = (count != FULL) && (state != DRAIN);
    enq    = in_valid && in_ready && !flush;
    cdb_out_valid = bcast && (!cur_op[3] || !rob_stall);
    pop    = cdb_out_valid && grnt;
  end

  assign cdb_out_tag  = bcast ? {{(TAG_W-ROB_W){1'b0}}, cur_rob} : '0;
  assign cdb_out_data = bcast ? res_data : '0;
  assign cdb_out_addr = bcast ? res_addr : '0;
  assign dcache_req   = (state == LD_REQ);
  assign dcache_addr  = dcache_req ? {cur_addr[ADDR_W-1:2], 2'b00} : '0;
`ifdef LSU_MISALIGN_EXC_EN
  assign cdb_out_exc  = bcast && res_exc;
`endif

  // Entry storage: enqueue, CDB operand snoop, pop at head
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_v   <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_v[i] && snoop && q_btag[i] == cdb_in_tag) begin
          q_btag[i] <= NOLOCK;
          q_base[i] <= cdb_in_data;
        end
        if (q_v[i] && snoop && q_stag[i] == cdb_in_tag) begin
          q_stag[i] <= NOLOCK;
          q_sd[i]   <= cdb_in_data;
        end
      end
      if (enq) begin
        q_v[tail]   <= 1'b1;
        q_op[tail]  <= in_op;
        q_rob[tail] <= in_rob;
        q_off[tail] <= in_offset;
        if (snoop && in_base_tag == cdb_in_tag) begin
          q_btag[tail] <= NOLOCK;
          q_base[tail] <= cdb_in_data;
        end else begin
          q_btag[tail] <= in_base_tag;
          q_base[tail] <= in_base;
        end
        if (!in_op[3] || (snoop && in_sd_tag == cdb_in_tag)) begin
          q_stag[tail] <= NOLOCK;
          q_sd[tail]   <= cdb_in_data;
        end else begin
          q_stag[tail] <= in_sd_tag;
          q_sd[tail]   <= in_sd;
        end
        tail <= tail + 1'b1;
      end
      if (pop) begin
        q_v[head] <= 1'b0;
        head      <= head + 1'b1;
      end
      if (enq && !pop)
        count <= count + 1'b1;
      else if (pop && !enq)
        count <= count - 1'b1;
    end
  end

  // Head execution FSM; a flushed in-flight load is drained, not broadcast
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cur_op   <= '0;
      cur_rob  <= '0;
      cur_addr <= '0;
      res_data <= '0;
      res_addr <= '0;
      res_exc  <= 1'b0;
    end else if (flush) begin
      if ((state == LD_WAIT && !dcache_done) ||
          (state == LD_REQ && dcache_ack) ||
          (state == DRAIN && !dcache_done))
        state <= DRAIN;
      else
        state <= IDLE;
    end else begin
      unique case (state)
        IDLE: if (h_rdy) begin
          cur_op   <= h_op;
          cur_rob  <= q_rob[head];
          cur_addr <= h_addr;
          res_exc  <= 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
          if ((h_op[1:0] == 2'd1 && h_addr[0]) ||
              (h_op[1:0] == 2'd2 && h_addr[1:0] != 2'b00)) begin
            res_exc  <= 1'b1;
            res_data <= '0;
            res_addr <= h_addr;
            state    <= BCAST;
          end else
`endif
          if (h_op[3]) begin
            res_data <= q_sd[head];
            res_addr <= h_addr;
            state    <= BCAST;
          end else begin
            res_addr <= '0;
            state    <= LD_REQ;
          end
        end
        LD_REQ:  if (dcache_ack) state <= LD_WAIT;
        LD_WAIT: if (dcache_done) begin
          res_data <= extract(cur_op, cur_addr[1:0], dcache_data);
          state    <= BCAST;
        end
        BCAST:   if (pop) state <= IDLE;
        DRAIN:   if (dcache_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
